// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - RV32 funct3 width codes used by loads and stores
//   - state_t, the encoding of the load/store unit sequencer
//   - is_half(), which is true for halfword width codes (h, hu)
// ---------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational byte/halfword lane logic shared by the load path and the
// read-modify-write store path.
// Ports:
//   rdata       in  32  word read from memory
//   sdata       in  32  store source; low byte/half is inserted
//   lane        in  2   byte offset within the word (addr[1:0])
//   funct3      in  3   RV32 width code
//   ext_data    out 32  addressed lane, sign or zero extended
//   merged_data out 32  rdata with the addressed byte/half replaced
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] sdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data,
    output logic [31:0] merged_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Select the addressed byte and half; half lane uses only lane[1].
    always_comb begin
        byte_val = rdata[7:0];
        case (lane)
            2'd0:    byte_val = rdata[7:0];
            2'd1:    byte_val = rdata[15:8];
            2'd2:    byte_val = rdata[23:16];
            default: byte_val = rdata[31:24];
        endcase
        half_val = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    // Load extension; unknown width codes yield zero (they are rejected
    // before reaching the load path anyway).
    always_comb begin
        ext_data = 32'h0;
        case (funct3)
            F3_B:    ext_data = {{24{byte_val[7]}}, byte_val};
            F3_BU:   ext_data = {24'h0, byte_val};
            F3_H:    ext_data = {{16{half_val[15]}}, half_val};
            F3_HU:   ext_data = {16'h0, half_val};
            F3_W:    ext_data = rdata;
            default: ext_data = 32'h0;
        endcase
    end

    // Store merge: the untouched lanes keep the memory contents.
    always_comb begin
        merged_data = rdata;
        if (is_half(funct3)) begin
            if (lane[1]) merged_data[31:16] = sdata[15:0];
            else         merged_data[15:0]  = sdata[15:0];
        end else if (funct3 == F3_B) begin
            case (lane)
                2'd0:    merged_data[7:0]   = sdata[7:0];
                2'd1:    merged_data[15:8]  = sdata[7:0];
                2'd2:    merged_data[23:16] = sdata[7:0];
                default: merged_data[31:24] = sdata[7:0];
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory interface. Takes one load/store request
// at a time, performs byte/half/word loads with extension, and does sub-word
// stores as read-modify-write against a word-wide memory with combinational
// read and posedge write. Bad requests complete immediately with err.
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   req_valid/req_ready     request handshake (ready only when idle)
//   is_store, funct3, addr  request kind, width and byte address
//   store_data              store source
//   resp_valid              one-cycle completion pulse
//   load_data, err          result and error flag, valid with resp_valid
//   mem_addr, mem_we,       word-aligned address, write enable and data
//   mem_wdata, mem_rdata    towards / from the data memory
// ---------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        resp_valid,
    output logic [31:0] load_data,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    state_t      next_state;

    logic [31:0] addr_q;
    logic [31:0] store_data_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;
    logic [31:0] wdata_q;

    logic        f3_legal;
    logic        misaligned;
    logic        out_of_range;
    logic        bad_req;

    logic [31:0] ext_data;
    logic [31:0] merged_data;

    lsu_align u_align (
        .rdata       (mem_rdata),
        .sdata       (store_data_q),
        .lane        (addr_q[1:0]),
        .funct3      (funct3_q),
        .ext_data    (ext_data),
        .merged_data (merged_data)
    );

    // Request validation on the live inputs, used only in the accept cycle.
    always_comb begin
        f3_legal = 1'b0;
        if (is_store)
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        else
            f3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                       (funct3 == F3_BU) || (funct3 == F3_HU);
        misaligned   = (is_half(funct3) && addr[0]) ||
                       ((funct3 == F3_W) && (addr[1:0] != 2'b00));
        out_of_range = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
        bad_req      = !f3_legal || misaligned || out_of_range;
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next-state decode; full words skip the read half of read-modify-write.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (bad_req)            next_state = ST_RESP;
                    else if (!is_store)     next_state = ST_LOAD;
                    else if (funct3 == F3_W) next_state = ST_WRITE;
                    else                    next_state = ST_READ;
                end
            end
            ST_LOAD:  next_state = ST_RESP;
            ST_READ:  next_state = ST_WRITE;
            ST_WRITE: next_state = ST_RESP;
            ST_RESP:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Request registers and results. wdata_q only changes when a write is
    // about to be issued, so mem_wdata holds its last value otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q       <= 32'h0;
            store_data_q <= 32'h0;
            funct3_q     <= 3'b000;
            is_store_q   <= 1'b0;
            wdata_q      <= 32'h0;
            load_data    <= 32'h0;
            err          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q       <= addr;
                        store_data_q <= store_data;
                        funct3_q     <= funct3;
                        is_store_q   <= is_store;
                        load_data    <= 32'h0;
                        err          <= bad_req;
                        if (is_store && (funct3 == F3_W) && !bad_req)
                            wdata_q <= store_data;
                    end
                end
                ST_LOAD: load_data <= is_store_q ? 32'h0 : ext_data;
                ST_READ: wdata_q   <= merged_data;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state so that reset removes mem_we immediately.
    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign mem_we     = (state == ST_WRITE);
    assign mem_wdata  = wdata_q;
    assign mem_addr   = (state == ST_IDLE) ? 32'h0 : {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Directed testbench for load_store_unit with a 32-word data memory model.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        resp_valid;
    logic [31:0] load_data;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:31];
    logic        pre_we;
    logic [4:0]  pre_idx;
    logic [31:0] pre_val;

    int assert_count = 0;
    int fail_count   = 0;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .resp_valid (resp_valid),
        .load_data  (load_data),
        .err        (err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, posedge write, bench preload port.
    assign mem_rdata = mem[mem_addr[6:2]];
    always @(posedge clk) begin
        if (mem_we)      mem[mem_addr[6:2]] <= mem_wdata;
        else if (pre_we) mem[pre_idx]       <= pre_val;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue one request from idle and watch it to completion. Cycle 1 is the
    // cycle right after the accept edge.
    task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output int lat, output logic [31:0] ld, output logic er,
                                 output int we_cyc, output int we_cnt, output logic [31:0] wd);
        lat = -1; we_cyc = -1; we_cnt = 0; ld = 32'h0; er = 1'b0; wd = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                we_cyc = c;
                wd = mem_wdata;
            end
            if (resp_valid) begin
                lat = c;
                ld  = load_data;
                er  = err;
                break;
            end
        end
    endtask

    int          lat, we_cyc, we_cnt;
    logic [31:0] ld, wd;
    logic        er;

    initial begin
        reset = 1'b1; req_valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; pre_we = 1'b0; pre_idx = 5'd0; pre_val = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp", 32'(resp_valid), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_ldata", load_data, 32'h0);
        checkOutput("rst_we", 32'(mem_we), 32'd0);
        checkOutput("rst_maddr", mem_addr, 32'h0);
        checkOutput("rst_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        preload(5'd0, 32'h11223344);
        preload(5'd1, 32'hDEADBEEF);
        preload(5'd2, 32'h8899AABB);
        preload(5'd4, 32'hCAFEF00D);

        // Loads with extension
        applyStimulus(1'b0, 3'b000, 32'h0B, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("lb_lat", 32'(lat), 32'd2);
        checkOutput("lb_data", ld, 32'hFFFFFF88);
        checkOutput("lb_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 3'b100, 32'h0A, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("lbu_data", ld, 32'h00000099);
        applyStimulus(1'b0, 3'b101, 32'h08, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("lhu_data", ld, 32'h0000AABB);
        applyStimulus(1'b0, 3'b001, 32'h0A, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("lh_data", ld, 32'hFFFF8899);
        applyStimulus(1'b0, 3'b010, 32'h08, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("lw_data", ld, 32'h8899AABB);
        checkOutput("lw_lat", 32'(lat), 32'd2);
        applyStimulus(1'b0, 3'b000, 32'h04, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("lb_pos_data", ld, 32'hFFFFFFEF);
        applyStimulus(1'b0, 3'b000, 32'h09, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("lb_lane1_data", ld, 32'hFFFFFFAA);

        // Halfword read-modify-write store
        applyStimulus(1'b1, 3'b001, 32'h06, 32'h00001234, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("sh_lat", 32'(lat), 32'd3);
        checkOutput("sh_we_cyc", 32'(we_cyc), 32'd2);
        checkOutput("sh_we_cnt", 32'(we_cnt), 32'd1);
        checkOutput("sh_wdata", wd, 32'h1234BEEF);
        checkOutput("sh_err", 32'(er), 32'd0);
        checkOutput("sh_mem", mem[1], 32'h1234BEEF);

        // Byte store into lane 1
        applyStimulus(1'b1, 3'b000, 32'h01, 32'h000000A5, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("sb_mem", mem[0], 32'h1122A544);

        // Bad requests
        applyStimulus(1'b0, 3'b010, 32'h05, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("lw_mis_err", 32'(er), 32'd1);
        checkOutput("lw_mis_lat", 32'(lat), 32'd1);
        checkOutput("lw_mis_data", ld, 32'h0);
        checkOutput("lw_mis_we", 32'(we_cnt), 32'd0);
        applyStimulus(1'b1, 3'b001, 32'h03, 32'h0000FFFF, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("sh_mis_err", 32'(er), 32'd1);
        checkOutput("sh_mis_lat", 32'(lat), 32'd1);
        checkOutput("sh_mis_we", 32'(we_cnt), 32'd0);
        checkOutput("sh_mis_mem", mem[0], 32'h1122A544);
        applyStimulus(1'b0, 3'b010, 32'h80, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("range_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 3'b010, 32'h7C, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("last_word_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 3'b011, 32'h08, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("ill_f3_err", 32'(er), 32'd1);
        checkOutput("ill_f3_data", ld, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'h08, 32'h0, lat, ld, er, we_cyc, we_cnt, wd);
        checkOutput("ill_st_err", 32'(er), 32'd1);
        checkOutput("ill_st_we", 32'(we_cnt), 32'd0);

        // Reset while in READ of a byte store
        we_cnt = 0;
        @(negedge clk);
        req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h10; store_data = 32'hA5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("midrst_ready", 32'(req_ready), 32'd1);
        checkOutput("midrst_we", 32'(mem_we), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (mem_we) we_cnt++;
            if (c == 1) reset = 1'b0;
        end
        checkOutput("midrst_we_cnt", 32'(we_cnt), 32'd0);
        checkOutput("midrst_mem", mem[4], 32'hCAFEF00D);

        // Back-to-back sw then lw with req_valid held
        begin
            int resp_first, resp_second, acc;
            resp_first = -1; resp_second = -1; acc = -1;
            @(negedge clk);
            req_valid = 1'b1; is_store = 1'b1; funct3 = 3'b010; addr = 32'h00; store_data = 32'h0BADCAFE;
            @(posedge clk);
            #1 is_store = 1'b0; store_data = 32'h0;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (resp_valid) begin
                    if (resp_first < 0) resp_first = c;
                    else begin
                        resp_second = c;
                        ld = load_data;
                        break;
                    end
                end
                if (req_ready && req_valid && acc < 0) begin
                    acc = c;
                    @(posedge clk);
                    #1 req_valid = 1'b0;
                end
            end
            checkOutput("b2b_resp1", 32'(resp_first), 32'd2);
            checkOutput("b2b_accept", 32'(acc), 32'd3);
            checkOutput("b2b_resp2", 32'(resp_second), 32'd5);
            checkOutput("b2b_data", ld, 32'h0BADCAFE);
            checkOutput("b2b_mem", mem[0], 32'h0BADCAFE);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // Hard time bound in case a wait never resolves.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got 0x00000000, expected 0x00000001");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
